// File: rtl/pixel_timing_pkg.sv
// Shared types and default 640x480 timing constants for the raster timing generator.
package pixel_timing_pkg;

  localparam int COORD_W = 10;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam logic DEF_SYNC_POL = 1'b0;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/pixel_timing_gen_axis.sv
// One raster axis: position counter plus ACTIVE/FRONT/SYNC/BACK phase FSM.
// Handshake: none; 'advance' is a single-cycle qualifier, one step per high cycle.
module sync_axis_counter
  import pixel_timing_pkg::COORD_W;
  import pixel_timing_pkg::phase_t;
  import pixel_timing_pkg::axis_total;
#(
  parameter int ACTIVE = 640,
  parameter int FP     = 16,
  parameter int SYNC   = 96,
  parameter int BP     = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               advance,
  output logic [COORD_W-1:0] count,
  output phase_t             phase,
  output phase_t             phase_next,
  output logic               wrap,
  output logic               sync
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);

  if (TOTAL > (1 << COORD_W) || ACTIVE < 1 || FP < 1 || SYNC < 1 || BP < 1) begin : g_bad_params
    $error("sync_axis_counter: segment widths must be >= 1 and total must fit COORD_W bits");
  end

  localparam logic [COORD_W-1:0] LAST_ACTIVE = COORD_W'(ACTIVE - 1);
  localparam logic [COORD_W-1:0] LAST_FRONT  = COORD_W'(ACTIVE + FP - 1);
  localparam logic [COORD_W-1:0] LAST_SYNC   = COORD_W'(ACTIVE + FP + SYNC - 1);
  localparam logic [COORD_W-1:0] LAST        = COORD_W'(TOTAL - 1);

  assign wrap = advance && (count == LAST);

  always_comb begin
    phase_next = phase;
    if (advance) begin
      case (phase)
        pixel_timing_pkg::ACTIVE: if (count == LAST_ACTIVE) phase_next = pixel_timing_pkg::FRONT;
        pixel_timing_pkg::FRONT:  if (count == LAST_FRONT)  phase_next = pixel_timing_pkg::SYNC;
        pixel_timing_pkg::SYNC:   if (count == LAST_SYNC)   phase_next = pixel_timing_pkg::BACK;
        pixel_timing_pkg::BACK:   if (count == LAST)        phase_next = pixel_timing_pkg::ACTIVE;
        default:                  phase_next = pixel_timing_pkg::ACTIVE;
      endcase
    end
  end

  // Sync level for the position being entered, so the top can register it alongside the counter.
  assign sync = (phase_next == pixel_timing_pkg::SYNC);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      phase <= pixel_timing_pkg::ACTIVE;
    end else if (advance) begin
      count <= wrap ? '0 : count + 1'b1;
      phase <= phase_next;
    end
  end

endmodule

// File: rtl/pixel_timing_gen.sv
// Raster timing generator: advances x/y on each enabled pixel_tick and drives registered
// hsync/vsync/de plus line_end/frame_start pulses aligned with the new position.
module pixel_timing_gen
  import pixel_timing_pkg::*;
#(
  parameter int   H_ACTIVE = DEF_H_ACTIVE,
  parameter int   H_FP     = DEF_H_FP,
  parameter int   H_SYNC   = DEF_H_SYNC,
  parameter int   H_BP     = DEF_H_BP,
  parameter int   V_ACTIVE = DEF_V_ACTIVE,
  parameter int   V_FP     = DEF_V_FP,
  parameter int   V_SYNC   = DEF_V_SYNC,
  parameter int   V_BP     = DEF_V_BP,
  parameter logic SYNC_POL = DEF_SYNC_POL
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               pixel_tick,
  output logic               hsync,
  output logic               vsync,
  output logic               de,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic               line_end,
  output logic               frame_start
);

  logic   advance;
  logic   v_advance;
  phase_t h_phase, h_phase_next;
  phase_t v_phase, v_phase_next;
  logic   h_wrap, v_wrap;
  logic   h_sync, v_sync;

  // A tick with enable low is simply dropped; nothing is remembered.
  assign advance   = enable & pixel_tick;
  assign v_advance = h_wrap;

  sync_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .count      (x),
    .phase      (h_phase),
    .phase_next (h_phase_next),
    .wrap       (h_wrap),
    .sync       (h_sync)
  );

  sync_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .clk        (clk),
    .rst        (rst),
    .advance    (v_advance),
    .count      (y),
    .phase      (v_phase),
    .phase_next (v_phase_next),
    .wrap       (v_wrap),
    .sync       (v_sync)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      de          <= 1'b1;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      line_end    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_end    <= h_wrap;
      frame_start <= h_wrap & v_wrap;
      if (advance) begin
        de    <= (h_phase_next == ACTIVE) && (v_phase_next == ACTIVE);
        hsync <= h_sync ? SYNC_POL : ~SYNC_POL;
        vsync <= v_sync ? SYNC_POL : ~SYNC_POL;
      end
    end
  end

endmodule

// File: tb/tb_pixel_timing_gen.sv
// Directed bench for pixel_timing_gen using an 8x6 raster (H=4/1/2/1, V=3/1/1/1, active-low syncs).
module tb_pixel_timing_gen;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       pixel_tick;
  logic       hsync, vsync, de, line_end, frame_start;
  logic [9:0] x, y;

  int checks = 0;
  int errors = 0;
  int px = 0;
  int py = 0;
  int fs_seen = 0;
  int le_seen = 0;

  pixel_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .pixel_tick  (pixel_tick),
    .hsync       (hsync),
    .vsync       (vsync),
    .de          (de),
    .x           (x),
    .y           (y),
    .line_end    (line_end),
    .frame_start (frame_start)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [9:0] observed, input logic [9:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  // One clock with the given inputs, then compare every output with the raster model.
  task automatic step(input logic r, input logic e, input logic t);
    logic exp_le, exp_fs;
    rst        = r;
    enable     = e;
    pixel_tick = t;
    @(posedge clk);
    #1;
    exp_le = 1'b0;
    exp_fs = 1'b0;
    if (r) begin
      px = 0;
      py = 0;
    end else if (e && t) begin
      if (px == 7) begin
        px     = 0;
        exp_le = 1'b1;
        if (py == 5) begin
          py     = 0;
          exp_fs = 1'b1;
        end else begin
          py++;
        end
      end else begin
        px++;
      end
    end
    check("x", x, 10'(px));
    check("y", y, 10'(py));
    check("de", {9'd0, de}, {9'd0, (px < 4) && (py < 3)});
    check("hsync", {9'd0, hsync}, {9'd0, !(px == 5 || px == 6)});
    check("vsync", {9'd0, vsync}, {9'd0, py != 4});
    check("line_end", {9'd0, line_end}, {9'd0, exp_le});
    check("frame_start", {9'd0, frame_start}, {9'd0, exp_fs});
    if (frame_start) fs_seen++;
    if (line_end) le_seen++;
  endtask

  initial begin
    rst        = 1'b1;
    enable     = 1'b0;
    pixel_tick = 1'b0;

    // Reset state
    step(1'b1, 1'b0, 1'b0);
    check("rst_x", x, 10'd0);
    check("rst_de", {9'd0, de}, 10'd1);
    check("rst_hsync", {9'd0, hsync}, 10'd1);

    // One line: 8 ticks
    le_seen = 0;
    repeat (8) step(1'b0, 1'b1, 1'b1);
    check("line_x", x, 10'd0);
    check("line_y", y, 10'd1);
    check("line_end_count", 10'(le_seen), 10'd1);

    // Rest of the frame: 48 ticks total from reset
    fs_seen = 0;
    repeat (40) step(1'b0, 1'b1, 1'b1);
    check("frame_x", x, 10'd0);
    check("frame_y", y, 10'd0);
    check("frame_start_count", 10'(fs_seen), 10'd1);

    // Divider cadence: tick every 8th cycle
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, (i % 8) == 0);
    check("cadence_x", x, 10'd5);
    check("cadence_hsync", {9'd0, hsync}, 10'd0);

    // Enable low with ticks present freezes at x=2,y=1
    step(1'b1, 1'b0, 1'b0);
    repeat (10) step(1'b0, 1'b1, 1'b1);
    check("freeze_x", x, 10'd2);
    check("freeze_y", y, 10'd1);
    le_seen = 0;
    repeat (20) step(1'b0, 1'b0, 1'b1);
    check("freeze_pulses", 10'(le_seen), 10'd0);
    step(1'b0, 1'b1, 1'b1);
    check("resume_x", x, 10'd3);
    check("resume_y", y, 10'd1);

    // Reset mid-frame at x=6,y=4 with both syncs low
    step(1'b1, 1'b0, 1'b0);
    repeat (38) step(1'b0, 1'b1, 1'b1);
    check("pre_rst_hsync", {9'd0, hsync}, 10'd0);
    check("pre_rst_vsync", {9'd0, vsync}, 10'd0);
    step(1'b1, 1'b0, 1'b0);
    check("mid_rst_x", x, 10'd0);
    check("mid_rst_vsync", {9'd0, vsync}, 10'd1);

    // Reset wins over a simultaneous tick
    repeat (3) step(1'b0, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1);
    check("rst_tick_x", x, 10'd0);
    check("rst_tick_de", {9'd0, de}, 10'd1);
    step(1'b0, 1'b1, 1'b1);
    check("after_rst_x", x, 10'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pixel_timing_gen.md
# pixel_timing_gen

Raster timing generator that consumes the divided pixel-rate strobe produced by the clock divider. It advances horizontal and vertical position counters once per strobe, tracks porch/sync/active phases on each axis, and drives registered hsync, vsync, data-enable and pixel coordinates to the downstream pixel fetch and output stages. Default parameters give 640x480 (800x525 total) timing.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, asserted level of hsync/vsync (0 = active-low)
- clk  in  1  system clock; single clock domain
- rst  in  1  reset, synchronous, active-high
- enable  in  1  run gate; low freezes all state
- pixel_tick  in  1  single-cycle pixel-rate strobe from the clock divider
- hsync  out  1  horizontal sync, level per SYNC_POL
- vsync  out  1  vertical sync, level per SYNC_POL
- de  out  1  high when both axes are in ACTIVE
- x  out  10  horizontal count (0..H_TOTAL-1)
- y  out  10  vertical count (0..V_TOTAL-1)
- line_end  out  1  one-cycle pulse on the advance that wraps x to 0
- frame_start  out  1  one-cycle pulse on the advance that wraps both x and y to 0

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL likewise; both must fit 10 bits (elaboration assertion).
- Advance condition: rising clk edge with rst=0, enable=1, pixel_tick=1. No advance otherwise; all outputs hold, pulses drop to 0.
- Horizontal: x increments by 1; at x=H_TOTAL-1, x wraps to 0 and y advances.
- Vertical: y increments on horizontal wrap; at y=V_TOTAL-1 with horizontal wrap, y wraps to 0.
- Per-axis phase FSM, order ACTIVE -> FRONT -> SYNC -> BACK -> ACTIVE:
  - ACTIVE: count in [0, ACTIVE-1]
  - FRONT: [ACTIVE, ACTIVE+FP-1]
  - SYNC: [ACTIVE+FP, ACTIVE+FP+SYNC-1]; sync output = SYNC_POL
  - BACK: remainder; transition to ACTIVE exactly at the wrap
- Vertical FSM transitions only on horizontal wrap; vsync changes aligned with x=0.
- de = (h_phase==ACTIVE) && (v_phase==ACTIVE).
- Phase is held as FSM state, never re-decoded from counters by consumers.
- A pixel_tick arriving while enable=0 is discarded, not queued.
- Deasserting enable mid-frame freezes position; re-enabling resumes from the frozen position.

## Timing
- All outputs registered; they reflect the new position in the same cycle the advanced counters do (computed from next-state values).
- Reset values: x=0, y=0, both phases ACTIVE, de=1, hsync=vsync=~SYNC_POL, line_end=0, frame_start=0.
- rst has priority over enable/pixel_tick; rst asserted mid-frame returns to the reset state on that edge.
- line_end and frame_start high for exactly one clk cycle per qualifying advance; frame_start implies line_end in the same cycle.
- pixel_tick held high on consecutive cycles advances once per cycle (no edge detection).

## Structure
- Shared package pixel_timing_pkg: phase_t enum {ACTIVE, FRONT, SYNC, BACK}; default 640x480 timing constants; COORD_W=10.
- Sub-module sync_axis_counter (parameters ACTIVE/FP/SYNC/BP, inputs advance, outputs count, phase, wrap, sync), instantiated twice; vertical advance = horizontal wrap & horizontal advance.
- Top level adds de, pulses and SYNC_POL output registers.

## Test plan
Benches use H=4/1/2/1 (H_TOTAL=8), V=3/1/1/1 (V_TOTAL=6), SYNC_POL=0.
- Reset then 8 ticks -> x runs 0..7 then 0; hsync low exactly at x=5,6; de high at x=0..3; line_end once, with x=0, y=1.
- 48 consecutive ticks -> one full frame; frame_start pulses once with x=0,y=0; vsync low only while y=4; de never high for y>=3.
- Tick every 8th cycle (divider cadence) -> outputs change only on tick cycles; pulses last one cycle.
- enable low for 20 cycles at x=2,y=1 with ticks present -> x,y,de,syncs frozen, no pulses; resumes at x=3 on first enabled tick.
- rst asserted at x=6,y=4 (hsync and vsync both low) -> next cycle x=0,y=0,de=1,hsync=vsync=1, pulses 0.
- rst and pixel_tick high together -> reset state, no advance.
